// File: rtl/rr_sched_pkg.sv
// Shared types, sizes and the round-robin pick helper for the grant scheduler.
package rr_sched_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // First set bit of req scanning upward from ptr, wrapping past the top index.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             found;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'(32'(ptr) + k);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/grant_decode_3to8.sv
// Enabled index-to-one-hot decoder; all zero while disabled.
module grant_decode_3to8
  import rr_sched_pkg::*;
(
  input  logic [IDX_W-1:0]   idx,
  input  logic               en,
  output logic [NUM_REQ-1:0] onehot_c
);

  // One-hot expansion of idx gated by en.
  always_comb begin
    onehot_c = '0;
    if (en) begin
      onehot_c[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_grant_scheduler_8.sv
// Round-robin scheduler sharing one resource among 8 requesters with a
// bounded hold budget and a single idle bubble between hand-offs.
module rr_grant_scheduler_8
  import rr_sched_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 grant_valid,
  output logic                 busy,
  output logic                 preempt
);

  localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);
  localparam bit               PREEMPT_EN = (MAX_HOLD != 0);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] others;

  // State, pointer, holder index and hold counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Arbitration, release/preemption decisions and hold counting.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    preempt = 1'b0;
    others  = req & ~(NUM_REQ'(1) << idx_q);
    case (state_q)
      IDLE: begin
        if (|req) begin
          idx_d   = rr_pick(req, ptr_q);
          cnt_d   = CNT_W'(1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req[idx_q]) begin
          // Release wins over a coincident preemption.
          state_d = IDLE;
          ptr_d   = idx_q + IDX_W'(1);
          cnt_d   = '0;
        end else if (PREEMPT_EN && (cnt_q == MAX_HOLD_C) && (|others)) begin
          preempt = 1'b1;
          state_d = IDLE;
          ptr_d   = idx_q + IDX_W'(1);
          cnt_d   = '0;
        end else if (cnt_q < MAX_HOLD_C) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q == GRANT);
  assign grant_valid = busy;
  assign grant_idx   = idx_q;

  grant_decode_3to8 u_grant_decode (
    .idx      (idx_q),
    .en       (busy),
    .onehot_c (grant)
  );

endmodule

// File: tb/tb_rr_grant_scheduler_8.sv
// Self-checking bench: directed vector table, hand-written corner sequences
// and randomized traffic against a behavioural round-robin model.
module tb_rr_grant_scheduler_8;

  localparam int MAXH = 3;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       busy;
  logic       preempt;

  int n_checks = 0;
  int n_fail   = 0;

  rr_grant_scheduler_8 #(.MAX_HOLD(MAXH), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .busy        (busy),
    .preempt     (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: who holds the resource, for how many cycles so far,
  // and where the next round-robin search starts.
  int m_busy, m_idx, m_ptr, m_held;

  function automatic logic [7:0] m_grant();
    return (m_busy != 0) ? 8'(1 << m_idx) : 8'h00;
  endfunction

  function automatic logic m_preempt(input logic [7:0] r);
    logic [7:0] rest;
    rest = r & ~8'(1 << m_idx);
    return (m_busy != 0) && (MAXH != 0) && (m_held == MAXH) && r[m_idx] && (rest != 8'h00);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_idx = 0; m_ptr = 0; m_held = 0;
  endtask

  task automatic model_step(input logic [7:0] r);
    if (m_busy == 0) begin
      for (int k = 0; k < 8; k++) begin
        if (r[(m_ptr + k) % 8]) begin
          m_idx  = (m_ptr + k) % 8;
          m_busy = 1;
          m_held = 1;
          break;
        end
      end
    end else if (!r[m_idx] || m_preempt(r)) begin
      m_busy = 0;
      m_ptr  = (m_idx + 1) % 8;
      m_held = 0;
    end else if (m_held < MAXH) begin
      m_held = m_held + 1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive req for this cycle and let combinational outputs settle.
  task automatic apply(input logic [7:0] r);
    req = r;
    #1;
  endtask

  // Take one clock edge, stepping the model with the sampled req.
  task automatic advance();
    @(posedge clk);
    model_step(req);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] g, input logic [2:0] i,
                         input logic b, input logic p);
    chk({tag, ".grant"},   32'(grant),       32'(g));
    chk({tag, ".idx"},     32'(grant_idx),   32'(i));
    chk({tag, ".busy"},    32'(busy),        32'(b));
    chk({tag, ".valid"},   32'(grant_valid), 32'(b));
    chk({tag, ".preempt"}, 32'(preempt),     32'(p));
  endtask

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [2:0] idx;
    logic       b;
    logic       p;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [7:0] r, input logic [7:0] g,
                              input logic [2:0] i, input logic b, input logic p);
    vec_t v;
    v.r = r; v.g = g; v.idx = i; v.b = b; v.p = p;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [7:0] r;

    // Directed sequence from reset; ptr starts at 0.
    for (int k = 0; k < 5; k++) add(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    add(8'h10, 8'h00, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) add(8'h10, 8'h10, 3'd4, 1'b1, 1'b0);
    add(8'h00, 8'h10, 3'd4, 1'b1, 1'b0);   // dropped: still granted this cycle
    add(8'h00, 8'h00, 3'd4, 1'b0, 1'b0);   // bubble, ptr now 5
    add(8'h21, 8'h00, 3'd4, 1'b0, 1'b0);   // ptr 5 prefers bit 5 over bit 0
    add(8'h00, 8'h20, 3'd5, 1'b1, 1'b0);
    add(8'h00, 8'h00, 3'd5, 1'b0, 1'b0);
    add(8'h81, 8'h00, 3'd5, 1'b0, 1'b0);   // ptr 6 -> idx 7
    add(8'h81, 8'h80, 3'd7, 1'b1, 1'b0);
    add(8'h81, 8'h80, 3'd7, 1'b1, 1'b0);
    add(8'h81, 8'h80, 3'd7, 1'b1, 1'b1);   // third cycle: forced rotation
    add(8'h81, 8'h00, 3'd7, 1'b0, 1'b0);   // bubble, ptr wraps to 0
    add(8'h81, 8'h01, 3'd0, 1'b1, 1'b0);
    add(8'h81, 8'h01, 3'd0, 1'b1, 1'b0);
    add(8'h81, 8'h01, 3'd0, 1'b1, 1'b1);
    add(8'h81, 8'h00, 3'd0, 1'b0, 1'b0);
    add(8'h00, 8'h80, 3'd7, 1'b1, 1'b0);
    add(8'h00, 8'h00, 3'd7, 1'b0, 1'b0);

    rst_n = 1'b0;
    req   = 8'h00;
    model_reset();
    #12;
    chk_all("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[n]) begin
      apply(tbl[n].r);
      chk_all($sformatf("vec%0d", n), tbl[n].g, tbl[n].idx, tbl[n].b, tbl[n].p);
      advance();
    end

    // Sole requester keeps the grant; no preemption, counter saturates.
    apply(8'h04);
    chk_all("solo.bubble", 8'h00, 3'd7, 1'b0, 1'b0);
    advance();
    for (int k = 0; k < 40; k++) begin
      apply(8'h04);
      chk_all($sformatf("solo%0d", k), 8'h04, 3'd2, 1'b1, 1'b0);
      advance();
    end
    chk("solo.cnt_sat", 32'(dut.cnt_q), 32'd3);

    // Holder drops on the budget cycle while another waits: release, no preempt.
    apply(8'h20);
    chk_all("relpre.drop", 8'h04, 3'd2, 1'b1, 1'b0);
    advance();
    apply(8'h20);
    chk_all("relpre.bubble", 8'h00, 3'd2, 1'b0, 1'b0);
    advance();
    apply(8'h20);
    chk_all("relpre.next", 8'h20, 3'd5, 1'b1, 1'b0);

    // Asynchronous reset between edges drops the grant at once.
    #3;
    rst_n = 1'b0;
    req   = 8'h00;
    #1;
    chk_all("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    advance();
    apply(8'hFF);
    chk_all("post_rst.bubble", 8'h00, 3'd0, 1'b0, 1'b0);
    advance();
    apply(8'hFF);
    chk_all("post_rst.grant", 8'h01, 3'd0, 1'b1, 1'b0);
    advance();

    // Randomized traffic with slowly toggling request bits against the model.
    r = 8'($urandom);
    for (int c = 0; c < 3000; c++) begin
      r = r ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      apply(r);
      chk_all("rand", m_grant(), 3'(m_idx), (m_busy != 0), m_preempt(r));
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
